// File: rtl/align_adder_if.sv
// ============================================================================
// Module      : align_adder_if
// Description : Operand/result handshake bundle for the align_adder stage.
//               slave is the adder's view, master is the producer/consumer view.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface align_adder_if;
    // Operand side
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        operator_in;

    // Result side
    logic        out_valid;
    logic        out_ready;
    logic        sign_out;
    logic [7:0]  exp_out;
    logic [25:0] mantis_out;
    logic        loss;
    logic        operator_out;

    modport slave (
        input  in_valid, a, b, operator_in, out_ready,
        output in_ready, out_valid, sign_out, exp_out, mantis_out, loss, operator_out
    );

    modport master (
        output in_valid, a, b, operator_in, out_ready,
        input  in_ready, out_valid, sign_out, exp_out, mantis_out, loss, operator_out
    );
endinterface

`default_nettype wire

// File: rtl/align_adder.sv
// ============================================================================
// Module      : align_adder
// Description : Unpacks two single-precision operands, orders them by
//               magnitude, right-aligns the smaller one bit-serially while
//               collecting a sticky bit, then adds or subtracts the mantissas.
//               Produces an unnormalized {sign, exp, mantissa, loss, op} result.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module align_adder #(
    parameter int SHIFT_LIMIT = 26
) (
    input  wire logic    clk,
    input  wire logic    rst,
    align_adder_if.slave bus
);

    localparam logic [7:0] c_shift_limit = 8'(SHIFT_LIMIT);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ALIGN = 2'd1,
        S_ADD   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_nxt;
    logic   w_in_ready;
    logic   w_out_valid;

    // Operand unpack and ordering (only consumed in IDLE)
    logic [7:0]  w_exp_a;
    logic [7:0]  w_exp_b;
    logic [25:0] w_m_a;
    logic [25:0] w_m_b;
    logic        w_sb_eff;
    logic        w_eff_sub;
    logic        w_a_big;
    logic [7:0]  w_exp_big;
    logic [7:0]  w_exp_small;
    logic [25:0] w_m_big;
    logic [25:0] w_m_small;
    logic        w_sign_big;
    logic [7:0]  w_d;
    logic        w_collapse;
    logic        w_needs_align;

    // Latched operation
    logic [25:0] r_big;
    logic [25:0] r_small;
    logic [7:0]  r_exp_big;
    logic        r_sign_big;
    logic        r_eff_sub;
    logic        r_sticky;
    logic [7:0]  r_cnt;
    logic [25:0] w_sum;

    // Result registers
    logic        r_sign_out;
    logic [7:0]  r_exp_out;
    logic [25:0] r_mantis_out;
    logic        r_loss;
    logic        r_op_out;

    // A zero exponent flushes the operand to zero regardless of its fraction
    assign w_exp_a = bus.a[30:23];
    assign w_exp_b = bus.b[30:23];
    assign w_m_a   = (w_exp_a != 8'd0) ? {2'b01, bus.a[22:0], 1'b0} : 26'd0;
    assign w_m_b   = (w_exp_b != 8'd0) ? {2'b01, bus.b[22:0], 1'b0} : 26'd0;

    assign w_sb_eff  = bus.b[31] ^ bus.operator_in;
    assign w_eff_sub = bus.a[31] ^ w_sb_eff;

    // Magnitude order on {exp, frac}; a tie keeps A as the big operand
    assign w_a_big     = (bus.a[30:0] >= bus.b[30:0]);
    assign w_exp_big   = w_a_big ? w_exp_a : w_exp_b;
    assign w_exp_small = w_a_big ? w_exp_b : w_exp_a;
    assign w_m_big     = w_a_big ? w_m_a   : w_m_b;
    assign w_m_small   = w_a_big ? w_m_b   : w_m_a;
    assign w_sign_big  = w_a_big ? bus.a[31] : w_sb_eff;

    assign w_d           = w_exp_big - w_exp_small;
    assign w_collapse    = (w_d >= c_shift_limit);
    assign w_needs_align = (w_d != 8'd0) && !w_collapse;

    // Both mantissas are below 2^25, so the 26-bit sum cannot overflow
    assign w_sum = r_eff_sub ? (r_big - r_small) : (r_big + r_small);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and handshake decode; handshake depends on state only
    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_in_ready = 1'b1;
                if (bus.in_valid) begin
                    w_state_nxt = w_needs_align ? S_ALIGN : S_ADD;
                end
            end
            S_ALIGN: begin
                if (r_cnt == 8'd1) begin
                    w_state_nxt = S_ADD;
                end
            end
            S_ADD: begin
                w_state_nxt = S_DONE;
            end
            S_DONE: begin
                w_out_valid = 1'b1;
                if (bus.out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Datapath: latch operands, shift one bit per cycle, then combine
    always_ff @(posedge clk) begin
        if (rst) begin
            r_big        <= 26'd0;
            r_small      <= 26'd0;
            r_exp_big    <= 8'd0;
            r_sign_big   <= 1'b0;
            r_eff_sub    <= 1'b0;
            r_sticky     <= 1'b0;
            r_cnt        <= 8'd0;
            r_sign_out   <= 1'b0;
            r_exp_out    <= 8'd0;
            r_mantis_out <= 26'd0;
            r_loss       <= 1'b0;
            r_op_out     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        r_big      <= w_m_big;
                        r_exp_big  <= w_exp_big;
                        r_sign_big <= w_sign_big;
                        r_eff_sub  <= w_eff_sub;
                        r_cnt      <= w_d;
                        r_op_out   <= bus.operator_in;
                        // Large distances skip the iteration: everything goes to sticky
                        if (w_collapse) begin
                            r_small  <= 26'd0;
                            r_sticky <= |w_m_small;
                        end else begin
                            r_small  <= w_m_small;
                            r_sticky <= 1'b0;
                        end
                    end
                end
                S_ALIGN: begin
                    r_small  <= {1'b0, r_small[25:1]};
                    r_sticky <= r_sticky | r_small[0];
                    r_cnt    <= r_cnt - 8'd1;
                end
                S_ADD: begin
                    r_mantis_out <= w_sum;
                    // Exact cancellation yields a canonical +0
                    if (r_eff_sub && (w_sum == 26'd0)) begin
                        r_sign_out <= 1'b0;
                        r_exp_out  <= 8'd0;
                        r_loss     <= 1'b0;
                    end else begin
                        r_sign_out <= r_sign_big;
                        r_exp_out  <= r_exp_big;
                        r_loss     <= r_sticky;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.in_ready     = w_in_ready;
    assign bus.out_valid    = w_out_valid;
    assign bus.sign_out     = r_sign_out;
    assign bus.exp_out      = r_exp_out;
    assign bus.mantis_out   = r_mantis_out;
    assign bus.loss         = r_loss;
    assign bus.operator_out = r_op_out;

endmodule

`default_nettype wire
